// File: rtl/flash_read_arbiter.sv
// ----------------------------------------------------------------------------
// flash_read_arbiter
//   Shares one QSPI flash read engine between the instruction-fetch port and
//   the data-load port, one outstanding transaction at a time. Loads win ties
//   except when fetch has been passed over STREAK_MAX times in a row. A fetch
//   flush marks an in-flight fetch for discard; the flash side still completes.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req_valid/addr   fetch request in;  if_req_ready  fetch grant (comb)
//   if_flush            cancel outstanding or same-cycle fetch
//   if_resp_valid/data  fetch response (registered, one-cycle strobe)
//   ld_req_valid/addr   load request in;   ld_req_ready  load grant (comb)
//   ld_resp_valid/data  load response (registered, one-cycle strobe)
//   fl_req_valid/addr   request to flash reader; fl_req_ready accept
//   fl_resp_valid/data  flash read data (one-cycle strobe)
// ----------------------------------------------------------------------------
module flash_read_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [XLEN-1:0]   if_resp_data,

    input  logic              ld_req_valid,
    input  logic [XLEN-1:0]   ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [XLEN-1:0]   ld_resp_data,

    output logic              fl_req_valid,
    output logic [ADDR_W-1:0] fl_req_addr,
    input  logic              fl_req_ready,
    input  logic              fl_resp_valid,
    input  logic [XLEN-1:0]   fl_resp_data
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_owner_ld;
    logic                  r_discard;
    logic [ADDR_W-1:0]     r_addr;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_if_resp_valid;
    logic [XLEN-1:0]       r_if_resp_data;
    logic                  r_ld_resp_valid;
    logic [XLEN-1:0]       r_ld_resp_data;

    logic                  w_if_eligible;
    logic                  w_grant_if;
    logic                  w_grant_ld;
    logic                  w_resp_take;
    logic                  w_unused;

    // A flushed fetch cannot be granted in the same cycle.
    assign w_if_eligible = if_req_valid && !if_flush;
    assign w_resp_take   = (r_state == ST_WAIT) && fl_resp_valid;

    // Address bits above the flash window are intentionally dropped.
    assign w_unused = ^{if_req_addr[XLEN-1:ADDR_W], ld_req_addr[XLEN-1:ADDR_W]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant logic.
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_ld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Load wins unless fetch has reached its starvation limit.
                if (ld_req_valid && !(w_if_eligible && (r_streak == STREAK_LIM))) begin
                    w_grant_ld = 1'b1;
                end else if (w_if_eligible) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_ld || w_grant_if) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fl_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fl_resp_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Transaction bookkeeping, streak counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_ld      <= 1'b0;
            r_discard       <= 1'b0;
            r_addr          <= '0;
            r_streak        <= '0;
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_data  <= '0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_ld_resp_valid <= 1'b0;

            if (w_grant_ld || w_grant_if) begin
                r_owner_ld <= w_grant_ld;
                r_addr     <= w_grant_ld ? ld_req_addr[ADDR_W-1:0]
                                         : if_req_addr[ADDR_W-1:0];
                r_discard  <= 1'b0;
            end else if ((r_state != ST_IDLE) && !r_owner_ld && if_flush) begin
                r_discard  <= 1'b1;
            end

            // Count loads that bypassed a waiting fetch; saturate at the limit.
            if (w_grant_ld) begin
                if (if_req_valid) begin
                    if (r_streak < STREAK_LIM) begin
                        r_streak <= r_streak + STREAK_W'(1);
                    end
                end else begin
                    r_streak <= '0;
                end
            end else if (w_grant_if) begin
                r_streak <= '0;
            end

            // A flush coinciding with the response also drops it.
            if (w_resp_take) begin
                if (r_owner_ld) begin
                    r_ld_resp_valid <= 1'b1;
                    r_ld_resp_data  <= fl_resp_data;
                end else if (!(r_discard || if_flush)) begin
                    r_if_resp_valid <= 1'b1;
                    r_if_resp_data  <= fl_resp_data;
                end
            end
        end
    end

    assign if_req_ready  = w_grant_if;
    assign ld_req_ready  = w_grant_ld;
    assign fl_req_valid  = (r_state == ST_ISSUE);
    assign fl_req_addr   = r_addr;
    assign if_resp_valid = r_if_resp_valid;
    assign if_resp_data  = r_if_resp_data;
    assign ld_resp_valid = r_ld_resp_valid;
    assign ld_resp_data  = r_ld_resp_data;

    // Flash data arriving outside WAIT has no owner and is dropped.
    a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst)
        fl_resp_valid |-> (r_state == ST_WAIT));

endmodule

// File: tb/tb_flash_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_flash_read_arbiter
//   Directed bench for flash_read_arbiter. The flash reader is played by the
//   stimulus sequence itself. Inputs change on the falling edge; outputs are
//   sampled on the falling edge (plus #1 for the combinational grants).
// ----------------------------------------------------------------------------
module tb_flash_read_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 24;

    logic              clk;
    logic              rst;
    logic              if_req_valid;
    logic [XLEN-1:0]   if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_resp_valid;
    logic [XLEN-1:0]   if_resp_data;
    logic              ld_req_valid;
    logic [XLEN-1:0]   ld_req_addr;
    logic              ld_req_ready;
    logic              ld_resp_valid;
    logic [XLEN-1:0]   ld_resp_data;
    logic              fl_req_valid;
    logic [ADDR_W-1:0] fl_req_addr;
    logic              fl_req_ready;
    logic              fl_resp_valid;
    logic [XLEN-1:0]   fl_resp_data;

    int checks = 0;
    int errors = 0;

    flash_read_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .STREAK_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_flush(if_flush),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
        .ld_req_ready(ld_req_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .fl_req_valid(fl_req_valid), .fl_req_addr(fl_req_addr),
        .fl_req_ready(fl_req_ready),
        .fl_resp_valid(fl_resp_valid), .fl_resp_data(fl_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plays the flash reader for one request issued at the previous grant:
    // checks the issued address, accepts it, returns data after lat cycles,
    // and leaves the bench on the falling edge where the response strobe shows.
    task automatic flash_serve(input string tag, input logic [31:0] exp_addr,
                               input logic [31:0] data, input int lat);
        chk({tag, "_fl_valid"}, 32'(fl_req_valid), 32'd1);
        chk({tag, "_fl_addr"}, 32'(fl_req_addr), exp_addr);
        fl_req_ready = 1'b1;
        tick();
        fl_req_ready = 1'b0;
        chk({tag, "_fl_valid_drop"}, 32'(fl_req_valid), 32'd0);
        for (int i = 1; i < lat; i++) tick();
        fl_resp_valid = 1'b1;
        fl_resp_data  = data;
        tick();
        fl_resp_valid = 1'b0;
        fl_resp_data  = '0;
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0;
        fl_req_ready = 1'b0; fl_resp_valid = 1'b0; fl_resp_data = '0;

        // Reset state
        @(negedge clk);
        tick();
        chk("rst_fl_valid", 32'(fl_req_valid), 32'd0);
        chk("rst_fl_addr", 32'(fl_req_addr), 32'd0);
        chk("rst_if_resp_valid", 32'(if_resp_valid), 32'd0);
        chk("rst_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("rst_if_resp_data", if_resp_data, 32'd0);
        chk("rst_ld_resp_data", ld_resp_data, 32'd0);
        rst = 1'b1;
        tick();
        #1;
        chk("idle_no_grant_if", 32'(if_req_ready), 32'd0);
        chk("idle_no_grant_ld", 32'(ld_req_ready), 32'd0);

        // Single fetch @0x4, flash latency 5
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0004;
        #1;
        chk("t1_if_ready", 32'(if_req_ready), 32'd1);
        chk("t1_ld_ready", 32'(ld_req_ready), 32'd0);
        tick();
        if_req_valid = 1'b0;
        flash_serve("t1", 32'h0000_0004, 32'hABCD_E137, 5);
        chk("t1_if_resp_valid", 32'(if_resp_valid), 32'd1);
        chk("t1_if_resp_data", if_resp_data, 32'hABCD_E137);
        chk("t1_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        tick();
        chk("t1_if_resp_pulse", 32'(if_resp_valid), 32'd0);
        chk("t1_if_resp_hold", if_resp_data, 32'hABCD_E137);

        // Simultaneous fetch @0x10 and load @0x20: load first
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0020;
        #1;
        chk("t2_ld_ready", 32'(ld_req_ready), 32'd1);
        chk("t2_if_ready", 32'(if_req_ready), 32'd0);
        tick();
        ld_req_valid = 1'b0;
        #1;
        chk("t2_busy_if_ready", 32'(if_req_ready), 32'd0);
        @(negedge clk);
        flash_serve("t2a", 32'h0000_0020, 32'h1111_2222, 2);
        chk("t2_ld_resp_valid", 32'(ld_resp_valid), 32'd1);
        chk("t2_ld_resp_data", ld_resp_data, 32'h1111_2222);
        chk("t2_if_resp_valid0", 32'(if_resp_valid), 32'd0);
        #1;
        chk("t2_if_ready_next", 32'(if_req_ready), 32'd1);
        tick();
        if_req_valid = 1'b0;
        flash_serve("t2b", 32'h0000_0010, 32'h3333_4444, 3);
        chk("t2_if_resp_valid", 32'(if_resp_valid), 32'd1);
        chk("t2_if_resp_data", if_resp_data, 32'h3333_4444);
        chk("t2_ld_resp_hold", ld_resp_data, 32'h1111_2222);

        // Starvation: both held valid; 4 loads, 1 fetch, then load again
        tick();
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0100;
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0200;
        for (int g = 0; g < 6; g++) begin
            logic exp_ld;
            exp_ld = (g != 4);
            #1;
            chk($sformatf("t3_g%0d_ld_ready", g), 32'(ld_req_ready), 32'(exp_ld));
            chk($sformatf("t3_g%0d_if_ready", g), 32'(if_req_ready), 32'(!exp_ld));
            tick();
            flash_serve($sformatf("t3_g%0d", g), exp_ld ? 32'h0000_0200 : 32'h0000_0100,
                        32'hD000_0000 + 32'(g), 1);
            chk($sformatf("t3_g%0d_ld_resp", g), 32'(ld_resp_valid), 32'(exp_ld));
            chk($sformatf("t3_g%0d_if_resp", g), 32'(if_resp_valid), 32'(!exp_ld));
        end
        chk("t3_if_data", if_resp_data, 32'hD000_0004);
        chk("t3_ld_data", ld_resp_data, 32'hD000_0005);
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        tick();

        // Flush in WAIT: fetch @0x8 dropped, then load @0x40 served
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0008;
        #1;
        chk("t4_if_ready", 32'(if_req_ready), 32'd1);
        tick();
        if_req_valid = 1'b0;
        chk("t4_fl_addr", 32'(fl_req_addr), 32'h0000_0008);
        fl_req_ready = 1'b1;
        tick();
        fl_req_ready = 1'b0;
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        tick();
        fl_resp_valid = 1'b1; fl_resp_data = 32'hBAD0_BAD0;
        tick();
        fl_resp_valid = 1'b0; fl_resp_data = '0;
        chk("t4_if_resp_dropped", 32'(if_resp_valid), 32'd0);
        chk("t4_if_data_hold", if_resp_data, 32'hD000_0004);
        ld_req_valid = 1'b1; ld_req_addr = 32'h0000_0040;
        #1;
        chk("t4_ld_ready", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        flash_serve("t4", 32'h0000_0040, 32'h4040_4040, 2);
        chk("t4_ld_resp_valid", 32'(ld_resp_valid), 32'd1);
        chk("t4_ld_resp_data", ld_resp_data, 32'h4040_4040);
        chk("t4_if_resp_valid", 32'(if_resp_valid), 32'd0);
        tick();

        // Flush in IDLE: same-cycle fetch blocked, granted next cycle
        if_req_valid = 1'b1; if_req_addr = 32'h0000_000C; if_flush = 1'b1;
        #1;
        chk("t5_if_ready_flush", 32'(if_req_ready), 32'd0);
        chk("t5_ld_ready_flush", 32'(ld_req_ready), 32'd0);
        tick();
        chk("t5_no_issue", 32'(fl_req_valid), 32'd0);
        if_flush = 1'b0;
        #1;
        chk("t5_if_ready_next", 32'(if_req_ready), 32'd1);
        tick();
        if_req_valid = 1'b0;
        flash_serve("t5", 32'h0000_000C, 32'h0C0C_0C0C, 2);
        chk("t5_if_resp_valid", 32'(if_resp_valid), 32'd1);
        chk("t5_if_resp_data", if_resp_data, 32'h0C0C_0C0C);
        tick();

        // Reset mid-WAIT, then a normal fetch
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0014;
        tick();
        if_req_valid = 1'b0;
        fl_req_ready = 1'b1;
        tick();
        fl_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_fl_valid", 32'(fl_req_valid), 32'd0);
        chk("t6_rst_fl_addr", 32'(fl_req_addr), 32'd0);
        chk("t6_rst_if_resp_valid", 32'(if_resp_valid), 32'd0);
        chk("t6_rst_if_resp_data", if_resp_data, 32'd0);
        chk("t6_rst_ld_resp_data", ld_resp_data, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_quiet%0d", i), 32'({if_resp_valid, ld_resp_valid, fl_req_valid}), 32'd0);
        end
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0018;
        #1;
        chk("t6_if_ready", 32'(if_req_ready), 32'd1);
        tick();
        if_req_valid = 1'b0;
        flash_serve("t6", 32'h0000_0018, 32'h1818_1818, 3);
        chk("t6_if_resp_valid", 32'(if_resp_valid), 32'd1);
        chk("t6_if_resp_data", if_resp_data, 32'h1818_1818);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the single QSPI flash read engine between the core's instruction-fetch port and its data-load port, one outstanding transaction at a time. Sits between the core (ifetch and load unit) and the flash reader in `basic_soc`. Applies data-priority arbitration with a bounded anti-starvation counter for fetch. Discards in-flight fetch responses when the core redirects the PC (branch/JAL flush).

## Interface
Parameters:
- `XLEN`, 32: requester address and data width.
- `ADDR_W`, 24: flash byte-address width; requester addresses are truncated to bits `[ADDR_W-1:0]`.
- `STREAK_MAX`, 4: maximum consecutive data grants while a fetch is pending (legal range 1..15).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `if_req_valid`  in  1  fetch request pending.
- `if_req_addr`  in  XLEN  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_flush`  in  1  cancel any outstanding or same-cycle fetch.
- `if_resp_valid`  out  1  one-cycle fetch response strobe.
- `if_resp_data`  out  XLEN  fetch response word.
- `ld_req_valid`  in  1  load request pending.
- `ld_req_addr`  in  XLEN  load address.
- `ld_req_ready`  out  1  load request accepted this cycle.
- `ld_resp_valid`  out  1  one-cycle load response strobe.
- `ld_resp_data`  out  XLEN  load response word.
- `fl_req_valid`  out  1  request to flash reader.
- `fl_req_addr`  out  ADDR_W  flash address.
- `fl_req_ready`  in  1  flash reader accepts request.
- `fl_resp_valid`  in  1  flash read data valid (one cycle).
- `fl_resp_data`  in  XLEN  flash read data.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: `if_req_ready`/`ld_req_ready` are combinational grants; at most one is high.
  - Only one requester valid: grant it.
  - Both valid: grant load, unless `streak == STREAK_MAX`, then grant fetch.
  - `if_flush` high: fetch is not granted that cycle; load may still be granted.
  - On grant: latch owner and `addr[ADDR_W-1:0]`, clear `discard`, go to ISSUE.
- ISSUE: `fl_req_valid=1`, `fl_req_addr` = latched address, held stable. On `fl_req_ready`, go to WAIT.
- WAIT: on `fl_resp_valid`, register data into the owner's `*_resp_data` and pulse the owner's `*_resp_valid` the next cycle, unless `discard` is set. Go to IDLE.
- Flush: `if_flush` while owner=fetch in ISSUE or WAIT sets `discard`. The transaction still completes on the flash side and the response is dropped. `if_flush` has no effect on a load-owned transaction.
- Streak counter, 4 bits:
  - Load grant while `if_req_valid` is high: increment, saturating at `STREAK_MAX`.
  - Any fetch grant: reset to 0.
  - Load grant with no fetch pending: reset to 0.
- `fl_resp_valid` outside WAIT is ignored (assertion in simulation).

## Timing
- Reset values: state IDLE; `fl_req_valid`, `if_resp_valid`, `ld_resp_valid` = 0; resp data, `fl_req_addr`, streak, `discard` = 0.
- Grant in cycle T gives `fl_req_valid` high from T+1.
- Flash accept in cycle A gives WAIT from A+1. `fl_req_ready` may already be high at T+1.
- `fl_resp_valid` in cycle R gives `*_resp_valid` in R+1 and IDLE in R+1. The next grant is possible in R+1.
- Minimum turnaround grant-to-grant: 3 cycles plus flash latency.
- `*_resp_data` holds its value until the next response to that port.
- Reset asserted mid-transaction: all state clears immediately and any pending response is lost. The flash reader is reset by the same `rst`.

## Test plan
- Single fetch: `if_req_valid` @0x0000_0004 with the flash returning 0xABCDE137 after 5 cycles. Expect `fl_req_addr=0x000004`, `if_resp_valid` one cycle after `fl_resp_valid`, data 0xABCDE137, `ld_resp_valid` never high.
- Simultaneous requests: fetch @0x10 and load @0x20 both valid in IDLE. Expect the load granted first (`fl_req_addr=0x20`), then the fetch (`0x10`), with streak returning to 0.
- Starvation, `STREAK_MAX=4`: load held valid continuously with fetch also valid. Expect exactly 4 load grants, then 1 fetch grant, then load again.
- Flush in WAIT: fetch @0x8 issued, `if_flush` pulsed before `fl_resp_valid`. Expect no `if_resp_valid`; a following load @0x40 is granted and answered normally.
- Flush in IDLE: `if_flush` and `if_req_valid` in the same cycle with no load pending. Expect `if_req_ready=0` that cycle and the grant on the next cycle if the request is still valid.
- Reset mid-WAIT: `rst` driven low during WAIT. Expect all outputs 0 immediately and no response strobe after release; the first post-reset fetch completes normally.
